// File: rtl/alu_param.sv
// Parametrised execute-stage ALU: combinational logic/arith ops with carry,
// overflow and zero flags, plus an abortable iterative restoring remainder unit.
module alu_param #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUOp,
  output logic [WIDTH-1:0] Result,
  output logic             C,
  output logic             V,
  output logic             Z,
  output logic             DZ,
  output logic             We
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;

  logic             is_mod;
  logic [WIDTH:0]   trial;
  logic             trial_ge;

  assign is_mod   = (ALUOp == OP_MOD);
  // Shift the next dividend bit into the partial remainder, then try to subtract.
  assign trial    = {rem[WIDTH-1:0], dvd[WIDTH-1]};
  assign trial_ge = (trial >= {1'b0, dvs});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mod) begin
            dvd   <= A;
            dvs   <= B;
            rem   <= '0;
            cnt   <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!is_mod) begin
            state <= ST_IDLE;
          end else begin
            dvd <= dvd << 1;
            rem <= trial_ge ? (trial - {1'b0, dvs}) : trial;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_STEP) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!is_mod) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // SUB and SLT share the adder as A + ~B + 1.
  logic             sub_op;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             add_v;

  assign sub_op = (ALUOp == OP_SUB) || (ALUOp == OP_SLT);
  assign b_eff  = sub_op ? ~B : B;
  assign sum    = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
  assign add_v  = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    Result = '0;
    C      = 1'b0;
    V      = 1'b0;
    DZ     = 1'b0;
    We     = 1'b1;
    case (ALUOp)
      OP_AND: Result = A & B;
      OP_OR:  Result = A | B;
      OP_XOR: Result = A ^ B;
      OP_NOR: Result = ~(A | B);
      OP_SLT: begin
        Result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_v};
        C      = sum[WIDTH];
      end
      OP_ADD, OP_SUB: begin
        Result = sum[WIDTH-1:0];
        C      = sum[WIDTH];
        V      = add_v;
      end
      default: begin
        if (state == ST_DONE) begin
          Result = rem[WIDTH-1:0];
          DZ     = (dvs == '0);
        end else begin
          We = 1'b0;
        end
      end
    endcase
  end

  assign Z = (Result == '0);

endmodule

// File: tb/tb_alu_param.sv
// Self-checking bench for alu_param: a 32-bit instance driven from a vector
// table plus MOD/abort/reset sequences, and an 8-bit instance regression.
module tb_alu_param;

  logic        clk;
  logic        rst;
  logic [31:0] a32, b32, res32;
  logic [2:0]  op32;
  logic        c32, v32, z32, dz32, we32;
  logic [7:0]  a8, b8, res8;
  logic [2:0]  op8;
  logic        c8, v8, z8, dz8, we8;

  int checks = 0;
  int passes = 0;

  alu_param #(.WIDTH(32)) dut32 (
    .Clk(clk), .Reset(rst), .A(a32), .B(b32), .ALUOp(op32),
    .Result(res32), .C(c32), .V(v32), .Z(z32), .DZ(dz32), .We(we32)
  );

  alu_param #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst), .A(a8), .B(b8), .ALUOp(op8),
    .Result(res8), .C(c8), .V(v8), .Z(z8), .DZ(dz8), .We(we8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic get_we(input int w);
    return (w == 8) ? we8 : we32;
  endfunction

  function automatic logic [63:0] get_res(input int w);
    return (w == 8) ? {56'd0, res8} : {32'd0, res32};
  endfunction

  function automatic logic get_dz(input int w);
    return (w == 8) ? dz8 : dz32;
  endfunction

  // Called right after ALUOp=111 is driven at a falling edge; counts low-We cycles.
  task automatic measure_mod(input int w, input int exp_low, input logic [63:0] exp_res,
                             input logic exp_dz, input bit scramble, input string tag);
    int  low;
    bit  done;
    low  = 0;
    done = 0;
    while (!done && low < 200) begin
      #1;
      if (get_we(w)) begin
        done = 1;
      end else begin
        low++;
        @(negedge clk);
        if (scramble && low == 5) begin
          a32 = 32'hDEAD_BEEF;
          b32 = 32'd3;
        end
      end
    end
    check({tag, " low cycles"}, 64'(low), 64'(exp_low));
    check({tag, " result"}, get_res(w), exp_res);
    check({tag, " dz"}, {63'd0, get_dz(w)}, {63'd0, exp_dz});
  endtask

  initial begin
    vecs[0]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b011, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{3'b101, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{3'b110, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b101, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b1};
    vecs[13] = '{3'b100, 32'h0000_0003, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b100, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    a32 = '0; b32 = '0; op32 = 3'b111;
    a8  = '0; b8  = '0; op8  = 3'b000;
    repeat (2) @(negedge clk);
    #1;
    check("reset we", {63'd0, we32}, 64'd0);
    check("reset result", {32'd0, res32}, 64'd0);
    check("reset z", {63'd0, z32}, 64'd1);
    @(negedge clk);
    rst  = 1'b0;
    op32 = 3'b000;

    // Combinational ops: results and flags in the same cycle.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      op32 = vecs[i].op;
      a32  = vecs[i].a;
      b32  = vecs[i].b;
      #1;
      check($sformatf("vec%0d result", i), {32'd0, res32}, {32'd0, vecs[i].res});
      check($sformatf("vec%0d c", i), {63'd0, c32}, {63'd0, vecs[i].c});
      check($sformatf("vec%0d v", i), {63'd0, v32}, {63'd0, vecs[i].v});
      check($sformatf("vec%0d z", i), {63'd0, z32}, {63'd0, vecs[i].z});
      check($sformatf("vec%0d we", i), {63'd0, we32}, 64'd1);
    end

    // Remainder of 100 by 7, held in DONE, then leaving DONE with AND in the same cycle.
    @(negedge clk);
    a32 = 32'd100; b32 = 32'd7; op32 = 3'b111;
    measure_mod(32, 33, 64'd2, 1'b0, 1'b0, "mod100_7");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("hold%0d result", k), {32'd0, res32}, 64'd2);
      check($sformatf("hold%0d we", k), {63'd0, we32}, 64'd1);
    end
    @(negedge clk);
    op32 = 3'b000;
    #1;
    check("leave done and", {32'd0, res32}, 64'd4);
    check("leave done we", {63'd0, we32}, 64'd1);

    // Abort at BUSY step 10, then restart with operands scrambled mid-run.
    @(negedge clk);
    op32 = 3'b111;
    #1;
    check("abort idle we", {63'd0, we32}, 64'd0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) op32 = 3'b000;
      #1;
      if (k == 5) begin
        check("busy result", {32'd0, res32}, 64'd0);
        check("busy z", {63'd0, z32}, 64'd1);
        check("busy we", {63'd0, we32}, 64'd0);
      end
    end
    check("abort result", {32'd0, res32}, 64'd4);
    check("abort we", {63'd0, we32}, 64'd1);
    @(negedge clk);
    op32 = 3'b111;
    measure_mod(32, 33, 64'd2, 1'b0, 1'b1, "restart");

    // Reset mid-BUSY, then a fresh MOD by zero.
    @(negedge clk);
    op32 = 3'b000; a32 = 32'd100; b32 = 32'd7;
    @(negedge clk);
    op32 = 3'b111;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset cycle we", {63'd0, we32}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a32 = 32'h1234; b32 = 32'd0;
    measure_mod(32, 33, 64'h1234, 1'b1, 1'b0, "post_reset_dz");

    // WIDTH=8 regression.
    @(negedge clk);
    op32 = 3'b000;
    op8 = 3'b101; a8 = 8'hFF; b8 = 8'h01;
    #1;
    check("w8 add result", {56'd0, res8}, 64'd0);
    check("w8 add c", {63'd0, c8}, 64'd1);
    check("w8 add v", {63'd0, v8}, 64'd0);
    check("w8 add z", {63'd0, z8}, 64'd1);
    @(negedge clk);
    op8 = 3'b111; a8 = 8'd200; b8 = 8'd13;
    measure_mod(8, 9, 64'd5, 1'b0, 1'b0, "w8_mod200_13");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_param.md
Name: alu_param

Overview:
- Parametrised-width successor of the 32-bit MIPS ALU; sits in the execute stage between the operand registers and writeback.
- Adds a working signed set-less-than, overflow/zero flags, a divide-by-zero flag and an abortable iterative remainder unit.
- ALUOp encoding is unchanged. The We handshake is kept: writeback stalls while a MOD is in flight.

Parameters:
- WIDTH, 32, datapath width in bits; legal range 2..64.

Ports:
- Clk  input  1  single clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUOp  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 SLT (signed), 101 ADD, 110 SUB, 111 MOD (unsigned A mod B).
- Result  output  WIDTH  selected result.
- C  output  1  carry-out of adder (ADD/SUB/SLT), else 0.
- V  output  1  signed overflow (ADD/SUB), else 0.
- Z  output  1  Result == 0.
- DZ  output  1  MOD with B == 0; valid only when We=1.
- We  output  1  Result/flags valid for writeback this cycle.

Behaviour:
- Ops 000–110 are purely combinational: Result, C, V and Z are valid in the same cycle, with We=1.
- SUB and SLT compute A + ~B + 1.
  - C = carry-out, so C=1 means no borrow.
  - V = (A[msb] != B[msb]) & (Sum[msb] != A[msb]).
- SLT: Result = {0…, Sum[msb] ^ V}. C follows the adder; V is forced to 0.
- Logic ops: C=0, V=0.
- MOD FSM has states IDLE, BUSY and DONE. Registers: remainder R (WIDTH+1 bits), dividend shift D (WIDTH), divisor Q (WIDTH), counter cnt (clog2(WIDTH+1) bits).
- IDLE:
  - If ALUOp==111 at an edge: capture D<=A, Q<=B, R<=0, cnt<=0, and go to BUSY.
  - We=0 during that IDLE cycle.
- BUSY, one restoring-division step per edge:
  - T = {R[WIDTH-1:0], D[msb]}; D <= D<<1.
  - If T >= Q then R <= T - Q, else R <= T.
  - cnt++.
  - After the WIDTH-th step, go to DONE.
  - We=0 throughout BUSY.
- Latency: from the first cycle ALUOp=111 is presented, We is low for exactly WIDTH+1 cycles; We rises in cycle WIDTH+2.
- DONE:
  - Result = R[WIDTH-1:0], We=1, DZ=(Q==0).
  - Held while ALUOp stays 111; no recompute.
  - Any other ALUOp returns the FSM to IDLE at the next edge.
  - Back-to-back MODs therefore need at least one non-MOD cycle between them.
- Abort: if ALUOp != 111 during BUSY, the FSM goes to IDLE at the next edge and discards the partial result. In that cycle the combinational op is output with We=1.
- Operand changes during BUSY are ignored because operands are captured at start.
- B==0: the algorithm naturally yields R = A. DZ=1 in DONE; no exception.
- While ALUOp==111 and state != DONE: Result=0, C=V=DZ=0, Z=1, We=0.
- Reset=1 at an edge:
  - state<=IDLE; R, D, Q, cnt <= 0.
  - This takes priority over everything, including mid-operation.
- During a Reset cycle, outputs follow the combinational rules for the current state. After reset with ALUOp=111, a MOD starts fresh.
- We = (ALUOp != 111) | (state == DONE).

Test Plan:
- ADD, WIDTH=32, A=0xFFFFFFFF, B=1 -> Result=0, C=1, Z=1, V=0, We=1 same cycle.
- SUB, A=0x80000000, B=1 -> Result=0x7FFFFFFF, V=1, C=1.
- SLT:
  - A=0xFFFFFFFF, B=1 -> Result=1.
  - A=0x7FFFFFFF, B=0x80000000 -> Result=0 (overflow case).
- MOD, A=100, B=7, ALUOp held at 111 -> We=0 for 33 cycles, then Result=2, We=1, DZ=0, held until ALUOp changes. With A=0x1234, B=0 -> Result=0x1234, DZ=1.
- Abort and reset:
  - Switch ALUOp to 000 at BUSY step 10 -> same cycle We=1 with Result=A&B. Returning to 111 restarts the full 33-cycle latency.
  - Reset asserted mid-BUSY -> IDLE next edge, then a fresh MOD.
- WIDTH=8 regression: 200 mod 13 -> Result=5 after 9 low-We cycles; ADD 0xFF+0x01 -> Result 0x00, C=1.
